// File: rtl/brush_painter_if.sv
// Command/status/frame-buffer bundle for brush_painter.
// clear_req exists only when BRUSH_PAINTER_CLEAR_EN is defined.
interface brush_painter_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 20
);
    logic                  start;
`ifdef BRUSH_PAINTER_CLEAR_EN
    logic                  clear_req;
`endif
    logic [9:0]            cur_x;
    logic [8:0]            cur_y;
    logic [3:0]            radius;
    logic [DATA_WIDTH-1:0] color;

    logic                  busy;
    logic                  done;
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] din;

    modport master (
`ifdef BRUSH_PAINTER_CLEAR_EN
        output clear_req,
`endif
        output start, cur_x, cur_y, radius, color,
        input  busy, done, we, write_addr, din
    );

    modport slave (
`ifdef BRUSH_PAINTER_CLEAR_EN
        input  clear_req,
`endif
        input  start, cur_x, cur_y, radius, color,
        output busy, done, we, write_addr, din
    );
endinterface

// File: rtl/brush_painter.sv
// Square-brush painter: streams one frame-buffer write per cycle over a clipped window.
// Optional full-frame clear is compiled in with macro BRUSH_PAINTER_CLEAR_EN.
module brush_painter #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 20
) (
    input  logic            clk,
    input  logic            rst,
    brush_painter_if.slave  bus_io
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAINT,
`ifdef BRUSH_PAINTER_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    localparam logic [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic [10:0] X_LIM = 11'(H_RES);
    localparam logic [9:0]  Y_MAX = 10'(V_RES - 1);
    localparam logic [9:0]  Y_LIM = 10'(V_RES);
`ifdef BRUSH_PAINTER_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
`endif

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        return ADDR_WIDTH'(y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(x);
    endfunction

    state_t                state_q, state_d;
    logic [9:0]            x_q, x_d;
    logic [8:0]            y_q, y_d;
    logic [9:0]            x_lo_q, x_lo_d;
    logic [9:0]            x_hi_q, x_hi_d;
    logic [8:0]            y_hi_q, y_hi_d;
    logic                  empty_q, empty_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // Window clipping is done in widened unsigned arithmetic so cur-radius never wraps.
    logic [10:0] cx_w, rad_x, x_sum;
    logic [9:0]  cy_w, rad_y, y_sum;
    logic [9:0]  x_lo_c, x_hi_c;
    logic [8:0]  y_lo_c, y_hi_c;
    logic        out_of_frame;

    always_comb begin
        cx_w         = {1'b0, bus_io.cur_x};
        rad_x        = {7'd0, bus_io.radius};
        x_sum        = cx_w + rad_x;
        cy_w         = {1'b0, bus_io.cur_y};
        rad_y        = {6'd0, bus_io.radius};
        y_sum        = cy_w + rad_y;
        x_lo_c       = (cx_w >= rad_x) ? 10'(cx_w - rad_x) : 10'd0;
        x_hi_c       = (x_sum > X_MAX) ? 10'(X_MAX) : x_sum[9:0];
        y_lo_c       = (cy_w >= rad_y) ? 9'(cy_w - rad_y) : 9'd0;
        y_hi_c       = (y_sum > Y_MAX) ? 9'(Y_MAX) : y_sum[8:0];
        out_of_frame = (cx_w >= X_LIM) || (cy_w >= Y_LIM);
    end

    logic [9:0] nx;
    logic [8:0] ny;
    logic       accept_clear;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x_lo_d  = x_lo_q;
        x_hi_d  = x_hi_q;
        y_hi_d  = y_hi_q;
        empty_d = empty_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        nx      = x_q;
        ny      = y_q;
`ifdef BRUSH_PAINTER_CLEAR_EN
        accept_clear = bus_io.clear_req;
`else
        accept_clear = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_clear) begin
`ifdef BRUSH_PAINTER_CLEAR_EN
                    state_d = S_CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = '0;
`endif
                end else if (bus_io.start) begin
                    state_d = S_PAINT;
                    x_lo_d  = x_lo_c;
                    x_hi_d  = x_hi_c;
                    y_hi_d  = y_hi_c;
                    din_d   = bus_io.color;
                    empty_d = out_of_frame;
                    x_d     = x_lo_c;
                    y_d     = y_lo_c;
                    // First pixel goes out on the accept edge so we rises one cycle after start.
                    if (!out_of_frame) begin
                        we_d   = 1'b1;
                        addr_d = pix_addr(x_lo_c, y_lo_c);
                    end
                end
            end

            S_PAINT: begin
                if (empty_q || (x_q == x_hi_q && y_q == y_hi_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == x_hi_q) begin
                        nx = x_lo_q;
                        ny = y_q + 9'd1;
                    end else begin
                        nx = x_q + 10'd1;
                    end
                    x_d    = nx;
                    y_d    = ny;
                    we_d   = 1'b1;
                    addr_d = pix_addr(nx, ny);
                end
            end

`ifdef BRUSH_PAINTER_CLEAR_EN
            S_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
`endif

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x_lo_q  <= '0;
            x_hi_q  <= '0;
            y_hi_q  <= '0;
            empty_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_lo_q  <= x_lo_d;
            x_hi_q  <= x_hi_d;
            y_hi_q  <= y_hi_d;
            empty_q <= empty_d;
            we_q    <= we_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign bus_io.busy       = (state_q != S_IDLE);
    assign bus_io.done       = done_q;
    assign bus_io.we         = we_q;
    assign bus_io.write_addr = addr_q;
    assign bus_io.din        = din_q;

endmodule

// File: tb/tb_brush_painter.sv
// Bench for brush_painter: directed and random brush strokes checked against a
// window-enumeration model; inputs are driven and outputs sampled on the falling edge.
module tb_brush_painter;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int DW = 3;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brush_painter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    brush_painter #(.H_RES(H), .V_RES(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    int passed = 0;
    int total  = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Expected address list: every pixel of the clipped square, rows top to bottom.
    task automatic model_paint(input int cx, input int cy, input int r);
        int xl, xh, yl, yh;
        exp_q.delete();
        if (cx >= H || cy >= V) return;
        xl = (cx - r < 0) ? 0 : cx - r;
        xh = (cx + r > H - 1) ? H - 1 : cx + r;
        yl = (cy - r < 0) ? 0 : cy - r;
        yh = (cy + r > V - 1) ? V - 1 : cy + r;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back(y * H + x);
    endtask

    task automatic noise();
        bus_if.start  = 1'($urandom_range(0, 1));
`ifdef BRUSH_PAINTER_CLEAR_EN
        bus_if.clear_req = 1'($urandom_range(0, 1));
`endif
        bus_if.cur_x  = 10'($urandom);
        bus_if.cur_y  = 9'($urandom);
        bus_if.radius = 4'($urandom);
        bus_if.color  = 3'($urandom);
    endtask

    task automatic quiet();
        bus_if.start = 1'b0;
`ifdef BRUSH_PAINTER_CLEAR_EN
        bus_if.clear_req = 1'b0;
`endif
    endtask

    task automatic issue(input int cx, input int cy, input int r, input int c);
        bus_if.cur_x  = 10'(cx);
        bus_if.cur_y  = 9'(cy);
        bus_if.radius = 4'(r);
        bus_if.color  = 3'(c);
        bus_if.start  = 1'b1;
        @(negedge clk);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle.
    task automatic paint(input int cx, input int cy, input int r, input int c);
        model_paint(cx, cy, r);
        issue(cx, cy, r, c);
        if (exp_q.size() == 0) begin
            check("empty_we", 32'(bus_if.we), 32'd0);
            check("empty_busy", 32'(bus_if.busy), 32'd1);
            check("empty_done_early", 32'(bus_if.done), 32'd0);
            noise();
            @(negedge clk);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            check("we", 32'(bus_if.we), 32'd1);
            check("addr", 32'(bus_if.write_addr), 32'(exp_q[i]));
            check("din", 32'(bus_if.din), 32'(c));
            check("done_early", 32'(bus_if.done), 32'd0);
            noise();
            @(negedge clk);
        end
        check("done_pulse", 32'(bus_if.done), 32'd1);
        check("done_we", 32'(bus_if.we), 32'd0);
        check("done_busy", 32'(bus_if.busy), 32'd1);
        quiet();
        @(negedge clk);
        check("idle_done", 32'(bus_if.done), 32'd0);
        check("idle_busy", 32'(bus_if.busy), 32'd0);
        check("idle_we", 32'(bus_if.we), 32'd0);
        $display("paint cx=%0d cy=%0d r=%0d c=%0d writes=%0d", cx, cy, r, c, exp_q.size());
    endtask

    initial begin
        quiet();
        bus_if.cur_x  = '0;
        bus_if.cur_y  = '0;
        bus_if.radius = '0;
        bus_if.color  = '0;
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_we", 32'(bus_if.we), 32'd0);
        check("rst_addr", 32'(bus_if.write_addr), 32'd0);
        check("rst_din", 32'(bus_if.din), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        paint(100, 50, 1, 5);
        paint(0, 0, 2, 3);
        paint(639, 479, 0, 7);
        paint(700, 10, 3, 1);
        paint(10, 480, 3, 2);
        paint(638, 1, 15, 6);

        // Reset partway through a 5x5 stroke.
        model_paint(200, 200, 2);
        issue(200, 200, 2, 4);
        for (int i = 0; i < 4; i++) begin
            check("pre_rst_addr", 32'(bus_if.write_addr), 32'(exp_q[i]));
            noise();
            @(negedge clk);
        end
        quiet();
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(bus_if.we), 32'd0);
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_addr", 32'(bus_if.write_addr), 32'd0);
        check("midrst_din", 32'(bus_if.din), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("inrst_we", 32'(bus_if.we), 32'd0);
            check("inrst_done", 32'(bus_if.done), 32'd0);
        end
        rst = 1'b0;
        $display("reset abort after 4 writes");
        paint(300, 100, 2, 2);

`ifdef BRUSH_PAINTER_CLEAR_EN
        bus_if.start     = 1'b1;
        bus_if.clear_req = 1'b1;
        bus_if.cur_x     = 10'd5;
        bus_if.cur_y     = 9'd5;
        bus_if.color     = 3'd7;
        @(negedge clk);
        for (int i = 0; i < H * V; i++) begin
            check("clr_we", 32'(bus_if.we), 32'd1);
            check("clr_addr", 32'(bus_if.write_addr), 32'(i));
            check("clr_din", 32'(bus_if.din), 32'd0);
            noise();
            @(negedge clk);
        end
        check("clr_done", 32'(bus_if.done), 32'd1);
        check("clr_done_we", 32'(bus_if.we), 32'd0);
        quiet();
        @(negedge clk);
        check("clr_idle", 32'(bus_if.busy), 32'd0);
        $display("clear writes=%0d", H * V);
`endif

        for (int n = 0; n < 25; n++) begin
            paint(int'($urandom_range(0, 719)), int'($urandom_range(0, 529)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
